// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 frame sequencer: register addresses, command width, FSM encodings.
// The optional row-difference mode (MAX7219_ROW_DIFF_EN) needs nothing from this package.
package max7219_pkg;

  localparam int CMD_W = 16;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIM   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_DISPTEST  = 4'hF;

  // Top-level sequencer states
  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_IDLE = 2'd2;
  localparam logic [1:0] ST_ROWS = 2'd3;

  // Word-issue handshake states; W_ISSUE is the only state with drv_en high
  localparam logic [2:0] W_IDLE  = 3'd0;
  localparam logic [2:0] W_ARM   = 3'd1;
  localparam logic [2:0] W_ISSUE = 3'd2;
  localparam logic [2:0] W_ACK   = 3'd3;
  localparam logic [2:0] W_DONE  = 3'd4;

  function automatic logic [CMD_W-1:0] make_cmd(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_word_issue.sv
// Hands one 16-bit command word to the serial shifter via its en/RDY handshake.
// drv_en pulses for one cycle only while RDY is high; drv_data holds until RDY returns.
module max7219_word_issue
  import max7219_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CMD_W-1:0] word,
  input  logic             drv_rdy,
  output logic             drv_en,
  output logic [CMD_W-1:0] drv_data,
  output logic             done
);

  logic [2:0]       state_r;
  logic             drv_en_r;
  logic [CMD_W-1:0] drv_data_r;

  // Handshake sequencing: issue, wait for RDY to drop (ack), wait for RDY to return (done)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= W_IDLE;
      drv_en_r   <= 1'b0;
      drv_data_r <= '0;
    end else begin
      drv_en_r <= 1'b0;
      case (state_r)
        W_IDLE: begin
          if (start) begin
            drv_data_r <= word;
            if (drv_rdy) begin
              drv_en_r <= 1'b1;
              state_r  <= W_ISSUE;
            end else begin
              state_r  <= W_ARM;
            end
          end
        end
        W_ARM: begin
          if (drv_rdy) begin
            drv_en_r <= 1'b1;
            state_r  <= W_ISSUE;
          end
        end
        W_ISSUE: state_r <= W_ACK;
        W_ACK:   if (!drv_rdy) state_r <= W_DONE;
        W_DONE:  if (drv_rdy) state_r <= W_IDLE;
        default: state_r <= W_IDLE;
      endcase
    end
  end

  // Completion is flagged in the cycle RDY comes back so the sequencer can move on at once
  assign done     = (state_r == W_DONE) && drv_rdy;
  assign drv_en   = drv_en_r;
  assign drv_data = drv_data_r;

endmodule

// File: rtl/max7219_frame_seq.sv
// MAX7219 command sequencer: init sequence after reset, then one DIGITn write per row of each 8x8 frame.
// Define MAX7219_ROW_DIFF_EN to skip rows unchanged since the last transmitted frame.
module max7219_frame_seq
  import max7219_pkg::*;
#(
  parameter logic [3:0] INTENSITY  = 4'h8,
  parameter logic [2:0] SCAN_LIMIT = 3'd7,
  parameter int         ROWS       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      frame_data,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic             busy,
  output logic             drv_en,
  output logic [CMD_W-1:0] drv_data,
  input  logic             drv_rdy
);

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  logic [1:0]       state_r;
  logic [2:0]       cmd_idx_r;
  logic [2:0]       row_idx_r;
  logic [63:0]      frame_r;
  logic             inflight_r;
  logic             frame_ready_r;
  logic             busy_r;
  logic             start_s;
  logic             skip_s;
  logic             done_s;
  logic [CMD_W-1:0] word_s;
  logic [CMD_W-1:0] init_word_s;
  logic [7:0]       row_byte_s;
`ifdef MAX7219_ROW_DIFF_EN
  logic [63:0]      shadow_r;
`endif

  assign row_byte_s = frame_r[{row_idx_r, 3'b000} +: 8];

  // Init command table
  always_comb begin
    init_word_s = make_cmd(REG_NOOP, 8'h00);
    case (cmd_idx_r)
      3'd0:    init_word_s = make_cmd(REG_SHUTDOWN, 8'h00);
      3'd1:    init_word_s = make_cmd(REG_DISPTEST, 8'h00);
      3'd2:    init_word_s = make_cmd(REG_DECODE, 8'h00);
      3'd3:    init_word_s = make_cmd(REG_INTENSITY, {4'h0, INTENSITY});
      3'd4:    init_word_s = make_cmd(REG_SCANLIM, {5'h00, SCAN_LIMIT});
      3'd5:    init_word_s = make_cmd(REG_SHUTDOWN, 8'h01);
      default: init_word_s = make_cmd(REG_NOOP, 8'h00);
    endcase
  end

  // Decide whether to launch the next word (or skip an unchanged row)
  always_comb begin
    start_s = 1'b0;
    skip_s  = 1'b0;
    word_s  = init_word_s;
    if (state_r == ST_INIT && !inflight_r) begin
      start_s = 1'b1;
    end else if (state_r == ST_ROWS && !inflight_r) begin
      word_s = make_cmd(REG_DIGIT0 + {1'b0, row_idx_r}, row_byte_s);
`ifdef MAX7219_ROW_DIFF_EN
      if (row_byte_s == shadow_r[{row_idx_r, 3'b000} +: 8]) begin
        skip_s = 1'b1;
      end else begin
        start_s = 1'b1;
      end
`else
      start_s = 1'b1;
`endif
    end else begin
      start_s = 1'b0;
    end
  end

  // Word sequencing across SYNC/INIT/IDLE/ROWS; status outputs registered with the transitions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_SYNC;
      cmd_idx_r     <= 3'd0;
      row_idx_r     <= 3'd0;
      frame_r       <= 64'h0;
      inflight_r    <= 1'b0;
      frame_ready_r <= 1'b0;
      busy_r        <= 1'b1;
`ifdef MAX7219_ROW_DIFF_EN
      shadow_r      <= 64'h0;
`endif
    end else begin
      case (state_r)
        ST_SYNC: begin
          cmd_idx_r <= 3'd0;
          if (drv_rdy) begin
            state_r  <= ST_INIT;
`ifdef MAX7219_ROW_DIFF_EN
            shadow_r <= 64'h0;
`endif
          end
        end
        ST_INIT: begin
          if (start_s) begin
            inflight_r <= 1'b1;
          end else if (done_s) begin
            inflight_r <= 1'b0;
            if (cmd_idx_r == 3'd5) begin
              state_r       <= ST_IDLE;
              frame_ready_r <= 1'b1;
              busy_r        <= 1'b0;
            end else begin
              cmd_idx_r <= cmd_idx_r + 3'd1;
            end
          end
        end
        ST_IDLE: begin
          if (frame_valid) begin
            frame_r       <= frame_data;
            row_idx_r     <= 3'd0;
            state_r       <= ST_ROWS;
            frame_ready_r <= 1'b0;
            busy_r        <= 1'b1;
          end
        end
        ST_ROWS: begin
          if (start_s) begin
            inflight_r <= 1'b1;
          end else if (done_s || skip_s) begin
            inflight_r <= 1'b0;
`ifdef MAX7219_ROW_DIFF_EN
            if (done_s) shadow_r[{row_idx_r, 3'b000} +: 8] <= row_byte_s;
`endif
            if (row_idx_r == LAST_ROW) begin
              state_r       <= ST_IDLE;
              frame_ready_r <= 1'b1;
              busy_r        <= 1'b0;
            end else begin
              row_idx_r <= row_idx_r + 3'd1;
            end
          end
        end
        default: state_r <= ST_SYNC;
      endcase
    end
  end

  max7219_word_issue u_issue (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_s),
    .word     (word_s),
    .drv_rdy  (drv_rdy),
    .drv_en   (drv_en),
    .drv_data (drv_data),
    .done     (done_s)
  );

  assign frame_ready = frame_ready_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_max7219_frame_seq.sv
// Directed bench for max7219_frame_seq with a behavioural shifter (40-cycle word latency).
// Row-difference expectations follow MAX7219_ROW_DIFF_EN when the bench is built with it.
module tb_max7219_frame_seq;

  localparam int LAT = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] frame_data = 64'h0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic        busy;
  logic        drv_en;
  logic [15:0] drv_data;
  logic        drv_rdy = 1'b1;

  int tests = 0;
  int fails = 0;
  int hs_viol = 0;
  int cnt_m = 0;
  logic        en_prev = 1'b0;
  logic        armed = 1'b0;
  logic [15:0] held = 16'h0;
  logic [15:0] log_q[$];

  localparam logic [63:0] F1 = 64'h8040201008040201;
  localparam logic [63:0] F2 = 64'h1122334455667788;
  localparam logic [63:0] F3 = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] F4 = 64'h0102030405060708;
  localparam logic [63:0] F1_R3 = 64'h80402010FF040201;

  logic [15:0] init_exp [6] = '{16'h0C00, 16'h0F00, 16'h0900, 16'h0A08, 16'h0B07, 16'h0C01};
  logic [15:0] f1_exp [8] = '{16'h0101, 16'h0202, 16'h0304, 16'h0408,
                              16'h0510, 16'h0620, 16'h0740, 16'h0880};

  always #5 clk = ~clk;

  max7219_frame_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .drv_en      (drv_en),
    .drv_data    (drv_data),
    .drv_rdy     (drv_rdy)
  );

  // Shifter model: accepts en while RDY, drops RDY next cycle, returns it after LAT cycles
  always @(posedge clk) begin
    if (drv_en && drv_rdy) begin
      drv_rdy <= 1'b0;
      cnt_m   <= LAT;
      log_q.push_back(drv_data);
    end else if (!drv_rdy) begin
      if (cnt_m <= 1) drv_rdy <= 1'b1;
      else cnt_m <= cnt_m - 1;
    end
  end

  // Handshake monitor
  always @(posedge clk) begin
    if (drv_en && en_prev) begin
      hs_viol = hs_viol + 1;
      $display("FAIL handshake_b2b: drv_en high two cycles in a row at %0t", $time);
    end
    if (drv_en && !drv_rdy) begin
      hs_viol = hs_viol + 1;
      $display("FAIL handshake_en_rdy: drv_en=1 while drv_rdy=0 at %0t", $time);
    end
    if (armed && !drv_rdy && drv_data !== held) begin
      hs_viol = hs_viol + 1;
      $display("FAIL handshake_stable: drv_data got %h expected %h at %0t", drv_data, held, $time);
    end
    en_prev <= drv_en;
    if (!rst_n) armed <= 1'b0;
    else if (drv_en && drv_rdy) begin
      armed <= 1'b1;
      held  <= drv_data;
    end
  end

  function automatic logic [15:0] row_word(input logic [63:0] f, input int r);
    return {4'h0, 4'(r + 1), f[8*r +: 8]};
  endfunction

  task automatic wait_ready(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (frame_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [63:0] f);
    bit ok;
    wait_ready(2000, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_ready: frame_ready got 0 expected 1 before send");
    end
    frame_data  = f;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests += 4;
    if (frame_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b expected 0", frame_ready); end
    if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b expected 1", busy); end
    if (drv_en !== 1'b0) begin fails++; $display("FAIL rst_en: got %b expected 0", drv_en); end
    if (drv_data !== 16'h0000) begin fails++; $display("FAIL rst_data: got %h expected 0000", drv_data); end
    log_q.delete();
    rst_n = 1'b1;
    wait_ready(2000, ok);
    tests += 3;
    if (!ok) begin fails++; $display("FAIL init_ready: frame_ready got 0 expected 1"); end
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
    if (log_q.size() != 6) begin fails++; $display("FAIL init_count: got %0d expected 6", log_q.size()); end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      tests++;
      if (log_q[i] !== init_exp[i]) begin
        fails++; $display("FAIL init_word%0d: got %h expected %h", i, log_q[i], init_exp[i]);
      end
    end
  endtask

  task automatic test_frame();
    bit busy_bad = 1'b0;
    bit ok = 1'b0;
    log_q.delete();
    send_frame(F1);
    tests += 2;
    if (frame_ready !== 1'b0) begin fails++; $display("FAIL frame_ready_low: got %b expected 0", frame_ready); end
    if (busy !== 1'b1) begin fails++; $display("FAIL frame_busy: got %b expected 1", busy); end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (frame_ready === 1'b1) begin ok = 1'b1; break; end
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
    tests += 3;
    if (!ok) begin fails++; $display("FAIL frame_done: frame_ready got 0 expected 1"); end
    if (busy_bad) begin fails++; $display("FAIL frame_busy_hold: busy got 0 expected 1 during rows"); end
    if (log_q.size() != 8) begin fails++; $display("FAIL frame_count: got %0d expected 8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      tests++;
      if (log_q[i] !== f1_exp[i]) begin
        fails++; $display("FAIL frame_word%0d: got %h expected %h", i, log_q[i], f1_exp[i]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    bit ok;
    log_q.delete();
    send_frame(F2);
    repeat (50) @(negedge clk);
    frame_data  = F3;
    frame_valid = 1'b1;
    repeat (3) @(negedge clk);
    frame_valid = 1'b0;
    wait_ready(2000, ok);
    tests += 2;
    if (!ok) begin fails++; $display("FAIL ignore_done: frame_ready got 0 expected 1"); end
    if (log_q.size() != 8) begin fails++; $display("FAIL ignore_count: got %0d expected 8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      tests++;
      if (log_q[i] !== row_word(F2, i)) begin
        fails++; $display("FAIL ignore_word%0d: got %h expected %h", i, log_q[i], row_word(F2, i));
      end
    end
    log_q.delete();
    send_frame(F3);
    wait_ready(2000, ok);
    tests += 2;
    if (!ok) begin fails++; $display("FAIL second_done: frame_ready got 0 expected 1"); end
    if (log_q.size() != 8) begin fails++; $display("FAIL second_count: got %0d expected 8", log_q.size()); end
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      tests++;
      if (log_q[i] !== row_word(F3, i)) begin
        fails++; $display("FAIL second_word%0d: got %h expected %h", i, log_q[i], row_word(F3, i));
      end
    end
  endtask

  task automatic test_reset_midword();
    bit ok = 1'b0;
    bit en_bad = 1'b0;
    send_frame(F4);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (drv_rdy === 1'b0) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL mid_word: drv_rdy got 1 expected 0"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    tests += 3;
    if (drv_en !== 1'b0) begin fails++; $display("FAIL mid_rst_en: got %b expected 0", drv_en); end
    if (busy !== 1'b1) begin fails++; $display("FAIL mid_rst_busy: got %b expected 1", busy); end
    if (frame_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready: got %b expected 0", frame_ready); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (drv_rdy === 1'b1) begin ok = 1'b1; break; end
      if (drv_en !== 1'b0) en_bad = 1'b1;
      @(negedge clk);
    end
    tests += 2;
    if (!ok) begin fails++; $display("FAIL mid_rdy_back: drv_rdy got 0 expected 1"); end
    if (en_bad) begin fails++; $display("FAIL mid_en_quiet: drv_en got 1 expected 0 while RDY low"); end
    wait_ready(2000, ok);
    tests += 2;
    if (!ok) begin fails++; $display("FAIL reinit_ready: frame_ready got 0 expected 1"); end
    if (log_q.size() != 6) begin fails++; $display("FAIL reinit_count: got %0d expected 6", log_q.size()); end
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      tests++;
      if (log_q[i] !== init_exp[i]) begin
        fails++; $display("FAIL reinit_word%0d: got %h expected %h", i, log_q[i], init_exp[i]);
      end
    end
  endtask

  task automatic test_row_diff();
    bit ok;
    int exp_n;
    log_q.delete();
    send_frame(F1);
    wait_ready(2000, ok);
    tests++;
    if (log_q.size() != 8) begin fails++; $display("FAIL diff_a_count: got %0d expected 8", log_q.size()); end
    log_q.delete();
    send_frame(F1_R3);
    wait_ready(2000, ok);
`ifdef MAX7219_ROW_DIFF_EN
    exp_n = 1;
    tests += 2;
    if (log_q.size() != exp_n) begin fails++; $display("FAIL diff_b_count: got %0d expected %0d", log_q.size(), exp_n); end
    if (log_q.size() > 0 && log_q[0] !== 16'h04FF) begin fails++; $display("FAIL diff_b_word: got %h expected 04ff", log_q[0]); end
`else
    exp_n = 8;
    tests += 2;
    if (log_q.size() != exp_n) begin fails++; $display("FAIL diff_b_count: got %0d expected %0d", log_q.size(), exp_n); end
    if (log_q.size() > 3 && log_q[3] !== 16'h04FF) begin fails++; $display("FAIL diff_b_word: got %h expected 04ff", log_q[3]); end
`endif
    log_q.delete();
    send_frame(F1_R3);
`ifdef MAX7219_ROW_DIFF_EN
    wait_ready(9, ok);
    exp_n = 0;
    tests += 2;
    if (!ok) begin fails++; $display("FAIL diff_same_idle: frame_ready got 0 expected 1 within 9 cycles"); end
    if (log_q.size() != exp_n) begin fails++; $display("FAIL diff_same_count: got %0d expected %0d", log_q.size(), exp_n); end
`else
    wait_ready(2000, ok);
    exp_n = 8;
    tests += 2;
    if (!ok) begin fails++; $display("FAIL diff_same_idle: frame_ready got 0 expected 1"); end
    if (log_q.size() != exp_n) begin fails++; $display("FAIL diff_same_count: got %0d expected %0d", log_q.size(), exp_n); end
`endif
  endtask

  task automatic test_handshake();
    tests++;
    if (hs_viol !== 0) begin fails++; $display("FAIL handshake_total: got %0d violations expected 0", hs_viol); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ignore_busy();
    test_reset_midword();
    test_row_diff();
    test_handshake();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
